// File: rtl/time_of_day_counter.sv
// BCD HH:MM time-of-day counter on the minute clock, with a two-state set handshake.
// Latency: count updates one edge after tick; a set commits one edge after accept. set_ready drops for the CHECK edge.
// Optional alarm comparator is built when TOD_ALARM_EN is defined.
module time_of_day_counter #(
  parameter logic [7:0] RESET_HH = 8'h00,
  parameter logic [7:0] RESET_MM = 8'h00
) (
  input  logic       min_clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  output logic       set_ready,
  output logic       set_ack,
  output logic       set_err,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic       hour_roll,
  output logic       day_roll
`ifdef TOD_ALARM_EN
  ,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  output logic       alarm_match
`endif
);

  typedef enum logic {ST_RUN = 1'b0, ST_CHECK = 1'b1} state_e;

  state_e     state_q;
  logic       set_ready_q, set_ack_q, set_err_q, hour_roll_q, day_roll_q;
  logic [7:0] hh_q, mm_q, lat_hh_q, lat_mm_q;
  logic [7:0] hh_d, mm_d, hh_inc, mm_inc;
  logic       mm_carry, hh_wrap, accept;
  logic       ack_d, err_d, hour_roll_d, day_roll_d;

  function automatic logic bcd_legal(input logic [7:0] h, input logic [7:0] m);
    return (h[3:0] <= 4'd9) && (h[7:4] <= 4'd2) && (h <= 8'h23) &&
           (m[3:0] <= 4'd9) && (m[7:4] <= 4'd5);
  endfunction

  // Increment candidates; hours advance only when the minutes carry out.
  always_comb begin
    mm_carry = 1'b0;
    hh_wrap  = 1'b0;
    if (mm_q[3:0] == 4'd9) begin
      if (mm_q[7:4] == 4'd5) begin
        mm_inc   = 8'h00;
        mm_carry = 1'b1;
      end else begin
        mm_inc = {mm_q[7:4] + 4'd1, 4'd0};
      end
    end else begin
      mm_inc = {mm_q[7:4], mm_q[3:0] + 4'd1};
    end
    if (hh_q == 8'h23) begin
      hh_inc  = 8'h00;
      hh_wrap = 1'b1;
    end else if (hh_q[3:0] == 4'd9) begin
      hh_inc = {hh_q[7:4] + 4'd1, 4'd0};
    end else begin
      hh_inc = {hh_q[7:4], hh_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    accept      = set_valid & set_ready_q;
    hh_d        = hh_q;
    mm_d        = mm_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    hour_roll_d = 1'b0;
    day_roll_d  = 1'b0;
    if (state_q == ST_CHECK) begin
      if (bcd_legal(lat_hh_q, lat_mm_q)) begin
        hh_d  = lat_hh_q;
        mm_d  = lat_mm_q;
        ack_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (!accept && tick_en) begin
      // Ticks coinciding with an accept are dropped so the set value wins.
      mm_d = mm_inc;
      if (mm_carry) begin
        hh_d        = hh_inc;
        hour_roll_d = 1'b1;
        day_roll_d  = hh_wrap;
      end
    end
  end

  always_ff @(posedge min_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      set_ready_q <= 1'b1;
      set_ack_q   <= 1'b0;
      set_err_q   <= 1'b0;
      hour_roll_q <= 1'b0;
      day_roll_q  <= 1'b0;
      hh_q        <= RESET_HH;
      mm_q        <= RESET_MM;
      lat_hh_q    <= 8'h00;
      lat_mm_q    <= 8'h00;
    end else begin
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      set_ack_q   <= ack_d;
      set_err_q   <= err_d;
      hour_roll_q <= hour_roll_d;
      day_roll_q  <= day_roll_d;
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            lat_hh_q    <= set_hh;
            lat_mm_q    <= set_mm;
            state_q     <= ST_CHECK;
            set_ready_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          state_q     <= ST_RUN;
          set_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_RUN;
          set_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef TOD_ALARM_EN
  logic alarm_match_q;

  // Only a transition onto the alarm time fires; holding there stays quiet.
  always_ff @(posedge min_clk or posedge reset) begin
    if (reset) begin
      alarm_match_q <= 1'b0;
    end else begin
      alarm_match_q <= alarm_arm && ({hh_d, mm_d} != {hh_q, mm_q}) &&
                       ({hh_d, mm_d} == {alarm_hh, alarm_mm});
    end
  end

  assign alarm_match = alarm_match_q;
`endif

  assign set_ready = set_ready_q;
  assign set_ack   = set_ack_q;
  assign set_err   = set_err_q;
  assign hh        = hh_q;
  assign mm        = mm_q;
  assign hour_roll = hour_roll_q;
  assign day_roll  = day_roll_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter; reference model keeps time as integer hours/minutes.
module tb_time_of_day_counter;

  localparam logic [7:0] RHH = 8'h12;
  localparam logic [7:0] RMM = 8'h34;

  typedef struct {
    logic [7:0] hh;
    logic [7:0] mm;
    logic       rdy;
    logic       ack;
    logic       err;
    logic       hr;
    logic       dr;
    logic       am;
  } exp_t;

  logic       min_clk = 1'b0;
  logic       reset;
  logic       tick_en;
  logic       set_valid;
  logic [7:0] set_hh, set_mm;
  logic       set_ready, set_ack, set_err, hour_roll, day_roll;
  logic [7:0] hh, mm;
`ifdef TOD_ALARM_EN
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_arm, alarm_match;
`endif

  always #5 min_clk = ~min_clk;

  time_of_day_counter #(.RESET_HH(RHH), .RESET_MM(RMM)) dut (
    .min_clk(min_clk), .reset(reset), .tick_en(tick_en),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm),
    .set_ready(set_ready), .set_ack(set_ack), .set_err(set_err),
    .hh(hh), .mm(mm), .hour_roll(hour_roll), .day_roll(day_roll)
`ifdef TOD_ALARM_EN
    , .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
    .alarm_match(alarm_match)
`endif
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // Reference model state
  int         m_h, m_m;
  bit         m_chk;
  logic [7:0] m_lhh, m_lmm;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, want);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit legal(input logic [7:0] h, input logic [7:0] m);
    if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || m[7:4] > 4'd9 || m[3:0] > 4'd9) return 1'b0;
    return (from_bcd(h) < 24) && (from_bcd(m) < 60);
  endfunction

  task automatic model_reset();
    m_h   = from_bcd(RHH);
    m_m   = from_bcd(RMM);
    m_chk = 1'b0;
  endtask

  function automatic exp_t quiet_exp();
    exp_t e;
    e.hh = to_bcd(m_h); e.mm = to_bcd(m_m); e.rdy = !m_chk;
    e.ack = 0; e.err = 0; e.hr = 0; e.dr = 0; e.am = 0;
    return e;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd0, 8'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_hh"},  hh,        e.hh);
    check({tag, "_mm"},  mm,        e.mm);
    check({tag, "_rdy"}, {7'd0, set_ready}, {7'd0, e.rdy});
    check({tag, "_ack"}, {7'd0, set_ack},   {7'd0, e.ack});
    check({tag, "_err"}, {7'd0, set_err},   {7'd0, e.err});
    check({tag, "_hr"},  {7'd0, hour_roll}, {7'd0, e.hr});
    check({tag, "_dr"},  {7'd0, day_roll},  {7'd0, e.dr});
`ifdef TOD_ALARM_EN
    check({tag, "_am"},  {7'd0, alarm_match}, {7'd0, e.am});
`endif
  endtask

  // Predict the effect of the coming edge, push it, clock, then compare.
  task automatic cycle(input string tag);
    exp_t e;
    int   oh, om;
    oh = m_h; om = m_m;
    e = quiet_exp();
    if (!m_chk) begin
      if (set_valid) begin
        m_lhh = set_hh; m_lmm = set_mm; m_chk = 1'b1;
      end else if (tick_en) begin
        m_m++;
        if (m_m == 60) begin
          m_m = 0; e.hr = 1; m_h++;
          if (m_h == 24) begin m_h = 0; e.dr = 1; end
        end
      end
    end else begin
      if (legal(m_lhh, m_lmm)) begin
        m_h = from_bcd(m_lhh); m_m = from_bcd(m_lmm); e.ack = 1;
      end else begin
        e.err = 1;
      end
      m_chk = 1'b0;
    end
`ifdef TOD_ALARM_EN
    e.am = alarm_arm && ((m_h != oh) || (m_m != om)) &&
           (to_bcd(m_h) == alarm_hh) && (to_bcd(m_m) == alarm_mm);
`endif
    e.hh = to_bcd(m_h); e.mm = to_bcd(m_m); e.rdy = !m_chk;
    sb_q.push_back(e);
    @(posedge min_clk); #1;
    compare_pop(tag);
  endtask

  task automatic check_now(input string tag);
    sb_q.push_back(quiet_exp());
    compare_pop(tag);
  endtask

  task automatic do_set(input string tag, input logic [7:0] h, input logic [7:0] m);
    set_hh = h; set_mm = m; set_valid = 1'b1;
    cycle({tag, "_acc"});
    cycle({tag, "_chk"});
    set_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_en = 1'b0; set_valid = 1'b0; set_hh = 8'h00; set_mm = 8'h00;
`ifdef TOD_ALARM_EN
    alarm_hh = 8'h06; alarm_mm = 8'h30; alarm_arm = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge min_clk);
    #1;
    check_now("rst_hold");
    reset = 1'b0;
    cycle("rst_rel");

    // Hour rollover without day rollover
    do_set("s0058", 8'h00, 8'h58);
    tick_en = 1'b1;
    cycle("t0059");
    cycle("t0100");
    tick_en = 1'b0;
    cycle("hold0100");

    do_set("s2359", 8'h23, 8'h59);
    tick_en = 1'b1; cycle("t0000"); tick_en = 1'b0; cycle("hold0000");
    do_set("s0959", 8'h09, 8'h59);
    tick_en = 1'b1; cycle("t1000"); tick_en = 1'b0;
    do_set("s1959", 8'h19, 8'h59);
    tick_en = 1'b1; cycle("t2000");

    // Set while ticking: ticks on accept and CHECK edges are discarded
    do_set("s0745", 8'h07, 8'h45);
    cycle("t0746");
    tick_en = 1'b0;

    do_set("bad2400", 8'h24, 8'h00);
    do_set("bad1260", 8'h12, 8'h60);
    do_set("bad1A00", 8'h1A, 8'h00);
    cycle("after_bad");

`ifdef TOD_ALARM_EN
    alarm_arm = 1'b1;
    do_set("s0629", 8'h06, 8'h29);
    tick_en = 1'b1; cycle("al0630"); tick_en = 1'b0;
    repeat (3) cycle("al_hold");
    alarm_arm = 1'b0;
    do_set("s0629b", 8'h06, 8'h29);
    tick_en = 1'b1; cycle("al_disarm"); tick_en = 1'b0;
`endif

    // Reset asserted while the set is in CHECK
    set_hh = 8'h05; set_mm = 8'h05; set_valid = 1'b1;
    cycle("rc_acc");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_now("rc_abort");
    set_valid = 1'b0;
    @(posedge min_clk); #1;
    reset = 1'b0;
    cycle("rc_post0");
    cycle("rc_post1");

    // Random traffic: ticks, legal and illegal sets, sporadic set_valid
    for (int i = 0; i < 300; i++) begin
      tick_en   = ($urandom_range(0, 3) != 0);
      set_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_hh = to_bcd($urandom_range(0, 23)); set_mm = to_bcd($urandom_range(0, 59));
      end else begin
        set_hh = 8'($urandom_range(0, 255)); set_mm = 8'($urandom_range(0, 255));
      end
`ifdef TOD_ALARM_EN
      alarm_arm = 1'b1;
      alarm_hh = to_bcd(m_h); alarm_mm = to_bcd((m_m + 1) % 60);
`endif
      cycle("rnd");
    end
    set_valid = 1'b0; tick_en = 1'b0;
    cycle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
